// File: rtl/bist_pkg.sv
// Shared March C- definitions: FSM encoding, element indices, the element
// table (direction, op count, op types) and the data-pattern bits.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_t;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  // A data bit is replicated across the full word: 0 -> all-zeros, 1 -> all-ones.
  localparam logic DATA0 = 1'b0;
  localparam logic DATA1 = 1'b1;

  typedef struct packed {
    logic is_write;
    logic data_bit;
  } march_op_t;

  localparam march_op_t OP_R0 = '{is_write: 1'b0, data_bit: DATA0};
  localparam march_op_t OP_R1 = '{is_write: 1'b0, data_bit: DATA1};
  localparam march_op_t OP_W0 = '{is_write: 1'b1, data_bit: DATA0};
  localparam march_op_t OP_W1 = '{is_write: 1'b1, data_bit: DATA1};

  typedef struct packed {
    logic      dir_up;
    logic      two_ops;
    march_op_t op0;
    march_op_t op1;
  } march_elem_t;

  // Single-op elements repeat op0 in op1 so the table stays uniform.
  function automatic march_elem_t elem_info(input logic [2:0] elem);
    march_elem_t d;
    case (elem)
      M0:      d = '{dir_up: 1'b1, two_ops: 1'b0, op0: OP_W0, op1: OP_W0};
      M1:      d = '{dir_up: 1'b1, two_ops: 1'b1, op0: OP_R0, op1: OP_W1};
      M2:      d = '{dir_up: 1'b1, two_ops: 1'b1, op0: OP_R1, op1: OP_W0};
      M3:      d = '{dir_up: 1'b0, two_ops: 1'b1, op0: OP_R0, op1: OP_W1};
      M4:      d = '{dir_up: 1'b0, two_ops: 1'b1, op0: OP_R1, op1: OP_W0};
      M5:      d = '{dir_up: 1'b0, two_ops: 1'b0, op0: OP_R0, op1: OP_R0};
      default: d = '{dir_up: 1'b0, two_ops: 1'b0, op0: OP_R0, op1: OP_R0};
    endcase
    return d;
  endfunction

  function automatic logic elem_is_up(input logic [2:0] elem);
    march_elem_t d;
    d = elem_info(elem);
    return d.dir_up;
  endfunction

endpackage

// File: rtl/bist_march_ctrl.sv
// March C- BIST controller: steers the external bist_addr_gen, issues RAM
// strobes one cycle later and compares read data two cycles after the decision.
//
// state    | meaning
// IDLE     | waiting for bist_start after reset
// CLR      | clearing the address generator (one cycle)
// RUN      | one March operation per cycle
// DRAIN    | two cycles flushing the last access and its compare
// DONE     | result held; bist_start reruns the test
module bist_march_ctrl
  import bist_pkg::*;
#(
  parameter int pADDR_WIDTH = 4,
  parameter int pDATA_WIDTH = 8
) (
  input  logic                   bist_clk,
  input  logic                   bist_rst_n,
  input  logic                   bist_start,
  input  logic                   max_addr_done,
  input  logic                   min_addr_done,
  output logic                   addr_clr_en,
  output logic                   addr_up_en,
  output logic                   addr_dn_en,
  output logic                   mem_ce,
  output logic                   mem_we,
  output logic [pDATA_WIDTH-1:0] mem_wdata,
  input  logic [pDATA_WIDTH-1:0] mem_rdata,
  output logic                   bist_busy,
  output logic                   bist_done,
  output logic                   bist_fail,
  output logic [pADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]             fail_elem
);

  bist_state_t state_q, state_d;
  logic [2:0]  elem_q, elem_d;
  logic        op_q, op_d;
  logic        drain_q, drain_d;

  // Shadow of the address generator, used only to tag reads for fail_addr.
  logic [pADDR_WIDTH-1:0] addr_q;

  march_elem_t cur;
  march_op_t   cur_op;
  logic        nxt_up;
  logic        last_op;
  logic        at_limit;
  logic        issue;
  logic        start_acc;
  logic [pDATA_WIDTH-1:0] op_data;

  logic                   s1_rd, s2_rd;
  logic [pDATA_WIDTH-1:0] s1_exp, s2_exp;
  logic [pADDR_WIDTH-1:0] s1_addr, s2_addr;
  logic [2:0]             s1_elem, s2_elem;
  logic                   miscompare;

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    op_d        = op_q;
    drain_d     = drain_q;
    addr_clr_en = 1'b0;
    addr_up_en  = 1'b0;
    addr_dn_en  = 1'b0;
    start_acc   = 1'b0;
    issue       = 1'b0;
    cur         = elem_info(elem_q);
    cur_op      = op_q ? cur.op1 : cur.op0;
    nxt_up      = elem_is_up(elem_q + 3'd1);
    last_op     = (op_q == cur.two_ops);
    at_limit    = cur.dir_up ? max_addr_done : min_addr_done;
    op_data     = {pDATA_WIDTH{cur_op.data_bit}};

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bist_start) begin
          state_d   = ST_CLR;
          start_acc = 1'b1;
        end
      end
      ST_CLR: begin
        addr_clr_en = 1'b1;
        state_d     = ST_RUN;
        elem_d      = M0;
        op_d        = 1'b0;
      end
      ST_RUN: begin
        issue = 1'b1;
        if (!last_op) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!at_limit) begin
            addr_up_en = cur.dir_up;
            addr_dn_en = !cur.dir_up;
          end else if (elem_q == M5) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
          end else begin
            // up->up and dn->dn wrap the counter; up->dn stays at the top address
            elem_d     = elem_q + 3'd1;
            addr_up_en = cur.dir_up && nxt_up;
            addr_dn_en = !cur.dir_up && !nxt_up;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n) begin
      state_q <= ST_IDLE;
      elem_q  <= M0;
      op_q    <= 1'b0;
      drain_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
      drain_q <= drain_d;
      if (addr_clr_en)     addr_q <= '0;
      else if (addr_up_en) addr_q <= addr_q + pADDR_WIDTH'(1);
      else if (addr_dn_en) addr_q <= addr_q - pADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n) begin
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      s1_rd     <= 1'b0;
      s1_exp    <= '0;
      s1_addr   <= '0;
      s1_elem   <= '0;
      s2_rd     <= 1'b0;
      s2_exp    <= '0;
      s2_addr   <= '0;
      s2_elem   <= '0;
    end else begin
      mem_ce    <= issue;
      mem_we    <= issue && cur_op.is_write;
      mem_wdata <= (issue && cur_op.is_write) ? op_data : '0;
      s1_rd     <= issue && !cur_op.is_write;
      s1_exp    <= op_data;
      s1_addr   <= addr_q;
      s1_elem   <= elem_q;
      s2_rd     <= s1_rd;
      s2_exp    <= s1_exp;
      s2_addr   <= s1_addr;
      s2_elem   <= s1_elem;
    end
  end

  assign miscompare = s2_rd && (mem_rdata != s2_exp);

  always_ff @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n) begin
      bist_fail <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else if (start_acc) begin
      bist_fail <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else if (miscompare) begin
      bist_fail <= 1'b1;
      if (!bist_fail) begin
        fail_addr <= s2_addr;
        fail_elem <= s2_elem;
      end
    end
  end

  assign bist_busy = (state_q == ST_CLR) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bist_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Bench for bist_march_ctrl: models the address generator and a faulty RAM,
// and checks each run against a March C- reference walk over an array.
module tb_bist_march_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NW = 16;

  logic          bist_clk = 1'b0;
  logic          bist_rst_n = 1'b0;
  logic          bist_start = 1'b0;
  logic          max_addr_done, min_addr_done;
  logic          addr_clr_en, addr_up_en, addr_dn_en;
  logic          mem_ce, mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          bist_busy, bist_done, bist_fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;

  logic [AW-1:0] cnt, bist_addr;
  logic [DW-1:0] mem [NW];
  logic [DW-1:0] init_mem [NW];

  int            f_kind = 0;
  logic [AW-1:0] f_addr = '0;
  logic [2:0]    f_bit = '0;
  logic          f_val = 1'b0;

  typedef logic [AW+DW:0] acc_t;
  acc_t obs_q[$];
  acc_t exp_q[$];

  int busy_cnt = 0, wrap_up = 0, wrap_dn = 0, multi_en = 0;
  int checks = 0, failures = 0;
  int run_base = 0;

  logic          exp_fail;
  logic [AW-1:0] exp_faddr;
  logic [2:0]    exp_felem;

  // op codes: 0=r0 1=r1 2=w0 3=w1
  int nops [6]    = '{1, 2, 2, 2, 2, 1};
  int opc  [6][2] = '{'{2, 2}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, 0}};
  bit up   [6]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  bist_march_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) dut (
    .bist_clk(bist_clk), .bist_rst_n(bist_rst_n), .bist_start(bist_start),
    .max_addr_done(max_addr_done), .min_addr_done(min_addr_done),
    .addr_clr_en(addr_clr_en), .addr_up_en(addr_up_en), .addr_dn_en(addr_dn_en),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem)
  );

  always #5 bist_clk = ~bist_clk;

  // Address generator: counter plus a one-cycle registered address output.
  always @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n) begin
      cnt       <= '0;
      bist_addr <= '0;
    end else begin
      bist_addr <= cnt;
      if (addr_clr_en)     cnt <= '0;
      else if (addr_up_en) cnt <= cnt + 1'b1;
      else if (addr_dn_en) cnt <= cnt - 1'b1;
    end
  end
  assign max_addr_done = (cnt == AW'(NW - 1));
  assign min_addr_done = (cnt == '0);

  // kind 1: stuck-at, 2: cannot fall 1->0, 3: cannot rise 0->1
  function automatic logic [DW-1:0] f_write(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                            input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = new_v;
    if (a == f_addr) begin
      case (f_kind)
        1: r[f_bit] = f_val;
        2: if (old_v[f_bit] && !new_v[f_bit]) r[f_bit] = 1'b1;
        3: if (!old_v[f_bit] && new_v[f_bit]) r[f_bit] = 1'b0;
        default: ;
      endcase
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] f_read(input logic [DW-1:0] v, input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = v;
    if (a == f_addr && f_kind == 1) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge bist_clk) begin
    if (mem_ce) begin
      if (mem_we) mem[bist_addr] = f_write(mem[bist_addr], mem_wdata, bist_addr);
      else        mem_rdata <= f_read(mem[bist_addr], bist_addr);
    end
  end

  always @(negedge bist_clk) begin
    if (bist_busy) busy_cnt++;
    if (mem_ce) obs_q.push_back({bist_addr, mem_we, mem_we ? mem_wdata : {DW{1'b0}}});
    if (addr_up_en && cnt == AW'(NW - 1)) wrap_up++;
    if (addr_dn_en && cnt == '0) wrap_dn++;
    if (int'(addr_clr_en) + int'(addr_up_en) + int'(addr_dn_en) > 1) multi_en++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: walk March C- over a plain array with the same fault model.
  task automatic ref_run();
    logic [DW-1:0] rm [NW];
    logic [DW-1:0] pat, v;
    logic [AW-1:0] ai;
    for (int i = 0; i < NW; i++) rm[i] = init_mem[i];
    exp_q.delete();
    exp_fail  = 1'b0;
    exp_faddr = '0;
    exp_felem = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < NW; i++) begin
        ai = up[e] ? AW'(i) : AW'(NW - 1 - i);
        for (int k = 0; k < nops[e]; k++) begin
          pat = (opc[e][k] % 2 == 1) ? {DW{1'b1}} : {DW{1'b0}};
          if (opc[e][k] >= 2) begin
            exp_q.push_back({ai, 1'b1, pat});
            rm[ai] = f_write(rm[ai], pat, ai);
          end else begin
            exp_q.push_back({ai, 1'b0, {DW{1'b0}}});
            v = f_read(rm[ai], ai);
            if (v != pat && !exp_fail) begin
              exp_fail  = 1'b1;
              exp_faddr = ai;
              exp_felem = 3'(e);
            end
          end
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge bist_clk);
    bist_start = 1'b1;
    @(negedge bist_clk);
    bist_start = 1'b0;
  endtask

  task automatic load_mem(input bit rnd);
    for (int i = 0; i < NW; i++) begin
      init_mem[i] = rnd ? DW'($urandom) : '0;
      mem[i]      = init_mem[i];
    end
  endtask

  task automatic run_full(input string nm, input int mid_start);
    int n, bb, wu, wd, me, nobs;
    ref_run();
    run_base = obs_q.size();
    bb = busy_cnt; wu = wrap_up; wd = wrap_dn; me = multi_en;
    pulse_start();
    check({nm, ".start_clear"}, 32'({bist_fail, fail_addr, fail_elem}), 32'(0));
    check({nm, ".busy"}, 32'(bist_busy), 32'(1));
    if (mid_start > 0) begin
      repeat (mid_start) @(negedge bist_clk);
      pulse_start();
    end
    n = 0;
    while (!bist_done && n < 600) begin
      @(negedge bist_clk);
      n++;
    end
    check({nm, ".done"}, 32'(bist_done), 32'(1));
    check({nm, ".busy_cycles"}, 32'(busy_cnt - bb), 32'(10 * NW + 3));
    nobs = obs_q.size() - run_base;
    check({nm, ".accesses"}, 32'(nobs), 32'(exp_q.size()));
    check({nm, ".fail"}, 32'(bist_fail), 32'(exp_fail));
    check({nm, ".fail_addr"}, 32'(fail_addr), 32'(exp_faddr));
    check({nm, ".fail_elem"}, 32'(fail_elem), 32'(exp_felem));
    check({nm, ".wrap_up"}, 32'(wrap_up - wu), 32'(2));
    check({nm, ".wrap_dn"}, 32'(wrap_dn - wd), 32'(2));
    check({nm, ".one_enable"}, 32'(multi_en - me), 32'(0));
    for (int i = 0; i < exp_q.size() && i < nobs; i++)
      check({nm, ".acc"}, 32'(obs_q[run_base + i]), 32'(exp_q[i]));
  endtask

  function automatic logic [AW-1:0] addr_at(input int i);
    acc_t t;
    t = obs_q[i];
    return t[AW+DW -: AW];
  endfunction

  initial begin
    int n, hold;
    load_mem(1'b0);

    repeat (2) @(negedge bist_clk);
    check("rst.flags", 32'({addr_clr_en, addr_up_en, addr_dn_en, mem_ce, mem_we,
                            bist_busy, bist_done, bist_fail}), 32'(0));
    check("rst.wdata", 32'(mem_wdata), 32'(0));
    check("rst.fail_info", 32'({fail_addr, fail_elem}), 32'(0));
    bist_rst_n = 1'b1;
    repeat (2) @(negedge bist_clk);
    check("idle.busy", 32'(bist_busy), 32'(0));

    // Fault-free pass and element boundary addresses.
    f_kind = 0;
    load_mem(1'b0);
    run_full("clean", 0);
    check("clean.fail_const", 32'(bist_fail), 32'(0));
    check("bnd.m0_last",  32'(addr_at(run_base + 15)),  32'(15));
    check("bnd.m1_first", 32'(addr_at(run_base + 16)),  32'(0));
    check("bnd.m2_last",  32'(addr_at(run_base + 79)),  32'(15));
    check("bnd.m3_first", 32'(addr_at(run_base + 80)),  32'(15));
    check("bnd.m3_last",  32'(addr_at(run_base + 111)), 32'(0));
    check("bnd.m4_first", 32'(addr_at(run_base + 112)), 32'(15));

    // Stuck-at-1 on bit 0 at address 5.
    f_kind = 1; f_addr = AW'(5); f_bit = 3'd0; f_val = 1'b1;
    load_mem(1'b0);
    run_full("sa1", 0);
    check("sa1.fail_addr_const", 32'(fail_addr), 32'(5));
    check("sa1.fail_elem_const", 32'(fail_elem), 32'(1));

    // Transition fault: bit 3 cannot fall at address 0xA.
    f_kind = 2; f_addr = AW'(10); f_bit = 3'd3;
    load_mem(1'b0);
    run_full("tf", 0);
    check("tf.fail_addr_const", 32'(fail_addr), 32'(10));
    check("tf.fail_elem_const", 32'(fail_elem), 32'(3));

    // Start pulsed during RUN is ignored; rerun from DONE clears the result.
    f_kind = 2; f_addr = AW'(10); f_bit = 3'd6;
    load_mem(1'b0);
    run_full("midstart", 40);
    f_kind = 0;
    load_mem(1'b0);
    run_full("rerun", 0);

    // Reset in the middle of M3 after an M1 failure was latched.
    f_kind = 1; f_addr = AW'(5); f_bit = 3'd0; f_val = 1'b1;
    load_mem(1'b0);
    n = obs_q.size();
    pulse_start();
    hold = 0;
    while (obs_q.size() - n < 90 && hold < 300) begin
      @(negedge bist_clk);
      hold++;
    end
    check("m3.reached", 32'(obs_q.size() - n >= 90), 32'(1));
    check("m3.fail_before_rst", 32'(bist_fail), 32'(1));
    bist_rst_n = 1'b0;
    #1;
    check("m3rst.flags", 32'({addr_clr_en, addr_up_en, addr_dn_en, mem_ce, mem_we,
                              bist_busy, bist_done, bist_fail}), 32'(0));
    check("m3rst.wdata", 32'(mem_wdata), 32'(0));
    check("m3rst.fail_info", 32'({fail_addr, fail_elem}), 32'(0));
    n = obs_q.size();
    repeat (3) @(negedge bist_clk);
    bist_rst_n = 1'b1;
    repeat (4) @(negedge bist_clk);
    check("m3rst.no_access", 32'(obs_q.size() - n), 32'(0));
    check("m3rst.stay_idle", 32'({bist_busy, bist_done}), 32'(0));
    f_kind = 0;
    load_mem(1'b0);
    run_full("after_rst", 0);

    // Randomized faults and initial contents.
    for (int r = 0; r < 6; r++) begin
      f_kind = int'($urandom_range(0, 3));
      f_addr = AW'($urandom_range(0, NW - 1));
      f_bit  = 3'($urandom_range(0, 7));
      f_val  = 1'($urandom_range(0, 1));
      load_mem(1'b1);
      run_full($sformatf("rnd%0d", r), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bist_march_ctrl.md
BIST_MARCH_CTRL -- requirements
Module: bist_march_ctrl

Interface
REQ-001 Parameter pADDR_WIDTH, default 4, is the address width and must match the bist_addr_gen instance.
REQ-002 Parameter pDATA_WIDTH, default 8, is the memory data width.
REQ-003 bist_clk  input  1  BIST clock; all logic is rising-edge.
REQ-004 bist_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 bist_start  input  1  one-cycle start pulse; ignored unless the block is in IDLE or DONE.
REQ-006 max_addr_done, min_addr_done  input  1 each  address-counter-at-limit flags from bist_addr_gen.
REQ-007 addr_clr_en, addr_up_en, addr_dn_en  output  1 each  address-counter controls to bist_addr_gen; at most one is high per cycle.
REQ-008 mem_ce, mem_we  output  1 each  memory chip enable and write enable, registered and aligned with bist_addr.
REQ-009 mem_wdata  output  pDATA_WIDTH  write data, registered.
REQ-010 mem_rdata  input  pDATA_WIDTH  synchronous-RAM read data, valid 1 cycle after a read strobe.
REQ-011 bist_busy, bist_done, bist_fail  output  1 each  status outputs.
REQ-012 fail_addr  output  pADDR_WIDTH  address of the first miscompare.
REQ-013 fail_elem  output  3  March element index of the first miscompare.

Function
REQ-014 The block shall execute March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 dn(r0,w1); M4 dn(r1,w0); M5 dn(r0).
REQ-015 Data "0" shall be all-zeros and data "1" shall be all-ones of pDATA_WIDTH.
REQ-016 FSM states shall be IDLE, CLR, RUN, DRAIN, DONE.
REQ-017 IDLE/DONE + bist_start -> CLR; in CLR, addr_clr_en=1 for one cycle; CLR -> RUN with elem=0, op=0.
REQ-018 RUN shall issue one operation per cycle, with the op index stepping through the current element.
REQ-019 Address step rule:
- On the last op of an element at a non-limit address, assert addr_up_en (up element) or addr_dn_en (down element); no enable on other ops.
- End of element is the last op with max_addr_done (up) or min_addr_done (down).
- At end of element, next-element handling: up->up assert addr_up_en (wraps to 0); up->dn assert no enable (stay at MAX); dn->dn assert addr_dn_en (wraps to MAX).
- End of M5 -> DRAIN.
REQ-020 Each op decided in cycle t shall drive mem_ce/mem_we/mem_wdata in cycle t+1, aligned with the 1-cycle-registered bist_addr.
REQ-021 For reads, expected data and address shall be pipelined; mem_rdata shall be compared in cycle t+2.
REQ-022 DRAIN shall last 2 cycles so the final read is compared; DRAIN -> DONE.
REQ-023 bist_done=1 in DONE; bist_busy=1 in CLR, RUN and DRAIN.
REQ-024 A miscompare shall set bist_fail (sticky).
REQ-025 fail_addr/fail_elem shall capture the first miscompare only; later failures do not overwrite them.
REQ-026 bist_fail, fail_addr and fail_elem shall clear on an accepted bist_start.
REQ-027 The total RUN length shall be 10*2^pADDR_WIDTH cycles.
REQ-028 The memory shall be idle (mem_ce=0) in IDLE, CLR, DRAIN and DONE, except for the pipelined last op.
REQ-029 A bist_start during CLR, RUN or DRAIN shall have no effect.

Reset
REQ-030 On reset: state=IDLE; all address enables, mem_ce, mem_we, bist_busy, bist_done and bist_fail = 0; mem_wdata, fail_addr and fail_elem = 0.
REQ-031 A reset asserted mid-test shall abort immediately with no further memory access; restart requires a new bist_start.

Structure
REQ-032 Shared package bist_pkg shall hold the FSM state encoding, the element-index constants M0-M5, the per-element direction/op-count/op-type table, and the data-pattern constants.
REQ-033 The block shall instantiate bist_addr_gen internally (with bist_addr exposed at top) or connect to it at the parent; the team's choice is parent connection.
REQ-034 No further sub-modules are required.

Verification
REQ-035 Reset then start with pADDR_WIDTH=4 and a fault-free RAM -> 160 RUN cycles, bist_done=1, bist_fail=0.
REQ-036 Stuck-at-1 on bit0 at address 0x5 -> bist_fail=1, fail_addr=0x5, fail_elem=1 (first r0).
REQ-037 Transition fault (cannot go 1->0) at address 0xA -> first fail at fail_elem=3, fail_addr=0xA.
REQ-038 Scoreboard of each element boundary:
- Address sequence after M2 stays at 0xF (no wrap);
- after M3 the address wraps 0x0->0xF via addr_dn_en;
- up->up boundaries wrap 0xF->0x0.
REQ-039 Reset asserted mid-M3 -> all outputs at reset values next cycle; a new start gives a clean pass.
REQ-040 bist_start pulsed during RUN is ignored; a second start from DONE clears bist_fail and reruns the test.
